switch_debouncer: RTL and testbench

Conditions the raw board switch inputs before they reach the SCIC `switches` port. Each bit is synchronised into the `clock` domain and filtered with a stability counter. The block presents a clean registered switch value, per-bit rising/falling pulses, and a sticky change flag the processor can poll and clear. It sits directly upstream of SCIC: `switches_out` drives SCIC's `switches` input.

---
 rtl/switch_debouncer_if.sv | 24 ++
 rtl/switch_debouncer.sv | 79 +++++++
 tb/tb_switch_debouncer.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/switch_debouncer_if.sv
// Switch conditioning interface between board-side logic and the debouncer.
// The master drives the raw switch levels and the flag clear; the slave returns the conditioned outputs.
`timescale 1ns/1ps
interface switch_debouncer_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] switches_raw;
  logic             flag_clear;
  logic [WIDTH-1:0] switches_out;
  logic [WIDTH-1:0] rise_pulse;
  logic [WIDTH-1:0] fall_pulse;
  logic             change_pulse;
  logic             change_flag;

  modport master (
    output switches_raw, flag_clear,
    input  switches_out, rise_pulse, fall_pulse, change_pulse, change_flag
  );

  modport slave (
    input  switches_raw, flag_clear,
    output switches_out, rise_pulse, fall_pulse, change_pulse, change_flag
  );
endinterface

// File: rtl/switch_debouncer.sv
// Per-bit two-flop synchroniser and stability-counter debouncer for board switches.
// Produces the clean switch value for SCIC, edge pulses, and a sticky change flag.
`timescale 1ns/1ps
module switch_debouncer #(
  parameter int WIDTH         = 4,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_WIDTH     = 20
) (
  input  logic             clock,
  input  logic             reset,
  switch_debouncer_if.slave sw
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0]     sync1;
  logic [WIDTH-1:0]     sync2;
  logic [CNT_WIDTH-1:0] cnt [WIDTH];
  logic [WIDTH-1:0]     out_q;
  logic [WIDTH-1:0]     rise_q;
  logic [WIDTH-1:0]     fall_q;
  logic                 change_q;
  logic                 flag_q;
  logic [WIDTH-1:0]     differs;
  logic [WIDTH-1:0]     accept;

  // A bit is accepted on the edge that completes STABLE_CYCLES consecutive differing samples.
  always_comb begin
    differs = sync2 ^ out_q;
    accept  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      accept[i] = differs[i] && (cnt[i] == CNT_LAST);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1    <= '0;
      sync2    <= '0;
      out_q    <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      change_q <= 1'b0;
      flag_q   <= 1'b0;
      // NOTE: the counters are a handful of flops, not a RAM, so they are reset so that a reset discards partial counts.
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments keep every register reading the pre-edge values of the others.
      sync1    <= sw.switches_raw;
      sync2    <= sync1;
      out_q    <= out_q ^ accept;
      rise_q   <= accept & sync2;
      fall_q   <= accept & ~sync2;
      change_q <= |accept;
      // Setting wins over a simultaneous clear.
      if (change_q) begin
        flag_q <= 1'b1;
      end else if (sw.flag_clear) begin
        flag_q <= 1'b0;
      end
      for (int i = 0; i < WIDTH; i++) begin
        if (!differs[i] || accept[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_WIDTH'(1);
        end
      end
    end
  end

  assign sw.switches_out = out_q;
  assign sw.rise_pulse   = rise_q;
  assign sw.fall_pulse   = fall_q;
  assign sw.change_pulse = change_q;
  assign sw.change_flag  = flag_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Self-checking bench for switch_debouncer: directed scenarios plus randomized switch activity
// compared every cycle against a sliding-window reference model.
`timescale 1ns/1ps
module tb_switch_debouncer;

  localparam int W = 4;
  localparam int S = 4;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  switch_debouncer_if #(.WIDTH(W)) sif ();

  switch_debouncer #(.WIDTH(W), .STABLE_CYCLES(S), .CNT_WIDTH(20)) dut (
    .clock (clock),
    .reset (reset),
    .sw    (sif)
  );

  always #5 clock = ~clock;

  // Reference model: a bit flips once the last S synchronised samples all differ from the debounced value.
  logic [W-1:0] m_s1, m_s2, m_out, m_rise, m_fall;
  logic         m_chg, m_flag;
  logic [W-1:0] hist [$];

  int rise_cnt [W];
  int fall_cnt [W];
  int tick_no;

  task automatic m_reset();
    m_s1 = '0; m_s2 = '0; m_out = '0; m_rise = '0; m_fall = '0;
    m_chg = 1'b0; m_flag = 1'b0;
    hist.delete();
    for (int k = 0; k < S; k++) hist.push_back('0);
  endtask

  task automatic m_step(input logic [W-1:0] raw, input logic fc);
    logic [W-1:0] acc;
    hist.push_back(m_s2);
    if (hist.size() > S) void'(hist.pop_front());
    acc = '1;
    foreach (hist[k]) acc &= hist[k] ^ m_out;
    m_flag = m_chg ? 1'b1 : (fc ? 1'b0 : m_flag);
    m_rise = acc & ~m_out;
    m_fall = acc & m_out;
    m_out  = m_out ^ acc;
    m_chg  = |acc;
    m_s2   = m_s1;
    m_s1   = raw;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".out"},  32'(sif.switches_out), 32'(m_out));
    check({tag, ".rise"}, 32'(sif.rise_pulse),   32'(m_rise));
    check({tag, ".fall"}, 32'(sif.fall_pulse),   32'(m_fall));
    check({tag, ".chg"},  32'(sif.change_pulse), 32'(m_chg));
    check({tag, ".flag"}, 32'(sif.change_flag),  32'(m_flag));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".out"},  32'(sif.switches_out), 32'd0);
    check({tag, ".rise"}, 32'(sif.rise_pulse),   32'd0);
    check({tag, ".fall"}, 32'(sif.fall_pulse),   32'd0);
    check({tag, ".chg"},  32'(sif.change_pulse), 32'd0);
    check({tag, ".flag"}, 32'(sif.change_flag),  32'd0);
  endtask

  task automatic clear_counts();
    for (int b = 0; b < W; b++) begin
      rise_cnt[b] = 0;
      fall_cnt[b] = 0;
    end
  endtask

  // One clock: model and DUT see the same pre-edge inputs; outputs compared 1 ns after the edge.
  task automatic tick(input string tag);
    @(posedge clock);
    m_step(sif.switches_raw, sif.flag_clear);
    #1;
    check_model(tag);
    for (int b = 0; b < W; b++) begin
      if (sif.rise_pulse[b] === 1'b1) rise_cnt[b]++;
      if (sif.fall_pulse[b] === 1'b1) fall_cnt[b]++;
    end
    tick_no++;
    @(negedge clock);
  endtask

  task automatic async_reset_pulse(input string tag);
    #2 reset = 1'b1;
    #1;
    check_all_zero(tag);
    m_reset();
    #1 reset = 1'b0;
  endtask

  initial begin
    logic [W-1:0] bounce;
    int           rise_at;

    reset = 1'b1;
    sif.switches_raw = '0;
    sif.flag_clear   = 1'b0;
    m_reset();
    clear_counts();
    tick_no = 0;
    #1;
    check_all_zero("reset_async");
    repeat (2) @(posedge clock);
    #1;
    check_all_zero("reset_held");
    @(negedge clock);
    reset = 1'b0;

    // Latency: raw sampled first at edge 0, accepted at edge 5.
    sif.switches_raw = 4'b0001;
    for (int e = 0; e <= 4; e++) tick("lat_wait");
    check("lat_out_before", 32'(sif.switches_out), 32'h0);
    tick("lat_edge5");
    check("lat_out",  32'(sif.switches_out), 32'h1);
    check("lat_rise", 32'(sif.rise_pulse),   32'h1);
    check("lat_chg",  32'(sif.change_pulse), 32'h1);

    // Flag priority: clear coincides with change_pulse, then clear alone.
    sif.flag_clear = 1'b1;
    tick("flag_set_wins");
    check("flag_set_wins", 32'(sif.change_flag), 32'h1);
    check("pulse_one_cycle", 32'(sif.change_pulse), 32'h0);
    tick("flag_clear");
    check("flag_cleared", 32'(sif.change_flag), 32'h0);
    sif.flag_clear = 1'b0;

    // Glitch of 3 cycles on bit1 is rejected.
    clear_counts();
    sif.switches_raw = 4'b0011;
    repeat (3) tick("glitch_hi");
    sif.switches_raw = 4'b0001;
    repeat (8) tick("glitch_lo");
    check("glitch_out", 32'(sif.switches_out), 32'h1);
    check("glitch_rise", 32'(rise_cnt[1]), 32'd0);
    sif.switches_raw = 4'b0011;
    repeat (6) tick("hold_bit1");
    sif.switches_raw = 4'b0011;
    repeat (3) tick("hold_bit1_post");
    check("hold_out", 32'(sif.switches_out), 32'h3);
    check("hold_rise", 32'(rise_cnt[1]), 32'd1);

    // Bounce on bit2 restarts the count; accepted 5 edges after the last 0->1.
    clear_counts();
    bounce  = '0;
    rise_at = -1;
    tick_no = 0;
    for (int i = 0; i < 14; i++) begin
      bounce[0] = (i == 3) ? 1'b0 : 1'b1;
      sif.switches_raw = {1'b0, bounce[0], 2'b11};
      if (i > 8) sif.switches_raw = 4'b0111;
      tick("bounce");
      if (sif.rise_pulse[2] === 1'b1) rise_at = i;
    end
    check("bounce_rise_cnt", 32'(rise_cnt[2]), 32'd1);
    check("bounce_rise_edge", 32'(rise_at), 32'd9);
    check("bounce_out", 32'(sif.switches_out), 32'h7);

    sif.switches_raw = 4'b1111;
    repeat (8) tick("to_all_ones");
    check("all_ones", 32'(sif.switches_out), 32'hF);

    // All bits fall together: a single change_pulse cycle.
    clear_counts();
    sif.switches_raw = 4'b0000;
    for (int e = 0; e <= 4; e++) tick("fall_wait");
    tick("fall_edge5");
    check("fall_out",   32'(sif.switches_out), 32'h0);
    check("fall_pulse", 32'(sif.fall_pulse),   32'hF);
    check("fall_chg",   32'(sif.change_pulse), 32'h1);
    repeat (3) tick("fall_after");
    for (int b = 0; b < W; b++) check("fall_once", 32'(fall_cnt[b]), 32'd1);

    // Async reset mid-count discards progress; a held 1 is re-accepted afterwards.
    sif.switches_raw = 4'b0001;
    repeat (3) tick("midcount");
    async_reset_pulse("midcount_rst");
    for (int e = 0; e <= 4; e++) tick("post_rst_wait");
    check("post_rst_before", 32'(sif.switches_out), 32'h0);
    tick("post_rst_edge5");
    check("post_rst_out",  32'(sif.switches_out), 32'h1);
    check("post_rst_rise", 32'(sif.rise_pulse),   32'h1);
    tick("post_rst_flag");
    async_reset_pulse("nonzero_rst");

    // Randomized activity with sticky raw levels and random flag clears.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) sif.switches_raw = W'($urandom);
      sif.flag_clear = ($urandom_range(3) == 0);
      tick("rand");
      if (i == 200) async_reset_pulse("rand_rst");
      for (int b = 0; b < W; b++) begin
        check("rand_excl", 32'(sif.rise_pulse[b] & sif.fall_pulse[b]), 32'd0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
